// File: rtl/encrypter_unit.sv
// Single encryption lane: word-wide key load, ROUNDS-cycle XOR/rotate/add cipher, valid/ack result hold.
// Optional ENCRYPTER_DECRYPT_EN adds i_decrypt, which runs the inverse rounds in reverse subkey order.
module encrypter_unit #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned KEY_WORDS  = 4,
   parameter int unsigned ROT_WIDTH  = 2,
   parameter int unsigned ROUNDS     = 4
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [DATA_WIDTH-1:0] i_data_in,
   input  logic [ROT_WIDTH-1:0]  i_key_rotation,
   input  logic                  i_program,
   input  logic                  i_data_ready,
`ifdef ENCRYPTER_DECRYPT_EN
   input  logic                  i_decrypt,
`endif
   output logic                  o_ready,
   output logic                  o_key_valid,
   output logic [DATA_WIDTH-1:0] o_result,
   output logic                  o_result_valid,
   input  logic                  i_result_ack
);

   localparam int unsigned RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t                r_fsm;
   logic [DATA_WIDTH-1:0] r_key [KEY_WORDS];
   logic [ROT_WIDTH-1:0]  r_cnt;
   logic [ROT_WIDTH-1:0]  r_idx;
   logic [RW-1:0]         r_round;
   logic [DATA_WIDTH-1:0] r_s;
   logic [DATA_WIDTH-1:0] r_result;
   logic                  r_key_valid;
   logic                  r_result_valid;
   logic                  r_dec;

   logic [RW-1:0]         w_rnd;
   logic [ROT_WIDTH-1:0]  w_kidx;
   logic [DATA_WIDTH-1:0] w_sk;
   logic [DATA_WIDTH-1:0] w_xor;
   logic [DATA_WIDTH-1:0] w_sub;
   logic [DATA_WIDTH-1:0] w_next;
   logic                  w_last;
   logic                  w_ready;

   assign w_ready        = (r_fsm == IDLE) & r_key_valid & ~r_result_valid;
   assign o_ready        = w_ready;
   assign o_key_valid    = r_key_valid;
   assign o_result       = r_result;
   assign o_result_valid = r_result_valid;

   // Decryption walks the subkeys backwards so round r of decrypt undoes round ROUNDS-1-r of encrypt.
   always_comb begin
      w_rnd  = r_dec ? (RW'(ROUNDS - 1) - r_round) : r_round;
      w_kidx = r_idx + ROT_WIDTH'(w_rnd);
      w_sk   = r_key[w_kidx];
      w_xor  = r_s ^ w_sk;
      w_sub  = r_s - w_sk;
      if (r_dec) begin
         w_next = {w_sub[2:0], w_sub[DATA_WIDTH-1:3]} ^ w_sk;
      end else begin
         w_next = {w_xor[DATA_WIDTH-4:0], w_xor[DATA_WIDTH-1:DATA_WIDTH-3]} + w_sk;
      end
      w_last = (r_round == RW'(ROUNDS - 1));
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_fsm          <= IDLE;
         for (int unsigned i = 0; i < KEY_WORDS; i++) begin
            r_key[i] <= '0;
         end
         r_cnt          <= '0;
         r_idx          <= '0;
         r_round        <= '0;
         r_s            <= '0;
         r_result       <= '0;
         r_key_valid    <= 1'b0;
         r_result_valid <= 1'b0;
         r_dec          <= 1'b0;
      end else begin
         case (r_fsm)
            IDLE: begin
               if (i_data_ready & i_program) begin
                  r_key[r_cnt] <= i_data_in;
                  if (r_cnt == ROT_WIDTH'(KEY_WORDS - 1)) begin
                     r_key_valid <= 1'b1;
                     r_cnt       <= '0;
                  end else begin
                     r_key_valid <= 1'b0;
                     r_cnt       <= r_cnt + ROT_WIDTH'(1);
                  end
               end
               if (r_result_valid & i_result_ack) begin
                  r_result_valid <= 1'b0;
               end else if (i_data_ready & ~i_program & w_ready) begin
                  r_s     <= i_data_in;
                  r_idx   <= i_key_rotation;
                  r_round <= '0;
`ifdef ENCRYPTER_DECRYPT_EN
                  r_dec   <= i_decrypt;
`else
                  r_dec   <= 1'b0;
`endif
                  r_fsm   <= BUSY;
               end
            end
            BUSY: begin
               r_s     <= w_next;
               r_round <= r_round + RW'(1);
               if (w_last) begin
                  r_result       <= w_next;
                  r_result_valid <= 1'b1;
                  r_fsm          <= IDLE;
               end
            end
            default: r_fsm <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_encrypter_unit.sv
// Self-checking bench for encrypter_unit: cycle-level reference model plus hand-computed vectors.
module tb_encrypter_unit;

   localparam int DW = 32;
   localparam int KW = 4;
   localparam int NR = 4;

   typedef bit [31:0] key_t [KW];

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] din = '0;
   logic [1:0]  rot = '0;
   logic        prog = 1'b0;
   logic        dr = 1'b0;
   logic        dec = 1'b0;
   logic        ack = 1'b0;
   logic        o_ready;
   logic        o_key_valid;
   logic [31:0] o_result;
   logic        o_result_valid;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   encrypter_unit #(.DATA_WIDTH(DW), .KEY_WORDS(KW), .ROT_WIDTH(2), .ROUNDS(NR)) dut (
      .i_clk          (clk),
      .i_reset        (rst_n),
      .i_data_in      (din),
      .i_key_rotation (rot),
      .i_program      (prog),
      .i_data_ready   (dr),
`ifdef ENCRYPTER_DECRYPT_EN
      .i_decrypt      (dec),
`endif
      .o_ready        (o_ready),
      .o_key_valid    (o_key_valid),
      .o_result       (o_result),
      .o_result_valid (o_result_valid),
      .i_result_ack   (ack)
   );

   function automatic bit [31:0] enc_f(key_t k, bit [31:0] d, int r0);
      bit [31:0] s, sk, t;
      s = d;
      for (int r = 0; r < NR; r++) begin
         sk = k[(r0 + r) % KW];
         t  = s ^ sk;
         s  = ((t << 3) | (t >> 29)) + sk;
      end
      return s;
   endfunction

   function automatic bit [31:0] dec_f(key_t k, bit [31:0] d, int r0);
      bit [31:0] s, sk, t;
      s = d;
      for (int r = NR - 1; r >= 0; r--) begin
         sk = k[(r0 + r) % KW];
         t  = s - sk;
         s  = ((t >> 3) | (t << 29)) ^ sk;
      end
      return s;
   endfunction

   // Reference model: key store, busy countdown and held result.
   key_t      m_key;
   int        m_cnt;
   bit        m_kv, m_rv, m_rdy;
   int        m_busy;
   bit [31:0] m_res, m_pend;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < KW; i++) m_key[i] = '0;
         m_cnt = 0; m_kv = 0; m_rv = 0; m_busy = 0; m_res = '0; m_pend = '0;
      end else begin
         m_rdy = (m_busy == 0) && m_kv && !m_rv;
         if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
               m_rv  = 1;
               m_res = m_pend;
            end
         end else begin
            if (dr && prog) begin
               m_key[m_cnt] = din;
               if (m_cnt == KW - 1) begin
                  m_kv = 1; m_cnt = 0;
               end else begin
                  m_kv = 0; m_cnt++;
               end
            end
            if (m_rv && ack) begin
               m_rv = 0;
            end else if (dr && !prog && m_rdy) begin
               m_pend = dec ? dec_f(m_key, din, int'(rot)) : enc_f(m_key, din, int'(rot));
               m_busy = NR;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         chk("cyc_ready", {31'b0, o_ready}, {31'b0, (m_busy == 0) && m_kv && !m_rv});
         chk("cyc_key_valid", {31'b0, o_key_valid}, {31'b0, m_kv});
         chk("cyc_result_valid", {31'b0, o_result_valid}, {31'b0, m_rv});
         chk("cyc_result", o_result, m_res);
      end
   end

   task automatic key_write(input logic [31:0] d);
      dr = 1; prog = 1; din = d;
      @(negedge clk);
      dr = 0; prog = 0;
   endtask

   task automatic send(input logic [31:0] d, input logic [1:0] r, input logic dc);
      dr = 1; prog = 0; din = d; rot = r; dec = dc;
      @(negedge clk);
      dr = 0; dec = 0;
   endtask

   task automatic wait_rv(output int cyc);
      cyc = 0;
      while (!o_result_valid && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      if (!o_result_valid) chk("wait_rv_timeout", 32'(o_result_valid), 32'd1);
   endtask

   task automatic ack_res();
      ack = 1;
      @(negedge clk);
      ack = 0;
   endtask

   key_t      kk;
   int        cyc;
   bit [31:0] r0, r3, c, d;
   logic [1:0] rr;

   initial begin
      #1;
      chk("rst_ready", 32'(o_ready), 32'd0);
      chk("rst_key_valid", 32'(o_key_valid), 32'd0);
      chk("rst_result", o_result, 32'd0);
      chk("rst_result_valid", 32'(o_result_valid), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1;
      @(negedge clk);

      // Zero key: data 1 becomes 1 rotated left 12 bits.
      repeat (4) key_write(32'h0);
      chk("t2_key_valid", 32'(o_key_valid), 32'd1);
      chk("t2_ready", 32'(o_ready), 32'd1);
      send(32'h1, 2'd0, 1'b0);
      wait_rv(cyc);
      chk("t2_latency", 32'(cyc), 32'd4);
      chk("t2_result", o_result, 32'h0000_1000);
      repeat (3) begin
         @(negedge clk);
         chk("t2_hold_rv", 32'(o_result_valid), 32'd1);
         chk("t2_hold_res", o_result, 32'h0000_1000);
      end
      ack_res();
      chk("t2_rv_cleared", 32'(o_result_valid), 32'd0);
      chk("t2_ready_back", 32'(o_ready), 32'd1);

      // Key 1..4, rotation 0 vs 3 (3 wraps to subkey 0).
      key_write(32'h1); key_write(32'h2); key_write(32'h3); key_write(32'h4);
      kk[0] = 32'h1; kk[1] = 32'h2; kk[2] = 32'h3; kk[3] = 32'h4;
      chk("t3_model_rot0", enc_f(kk, 32'h0, 0), 32'h0000_167C);
      chk("t3_model_rot3", enc_f(kk, 32'h0, 3), 32'h0000_4ACB);
      send(32'h0, 2'd0, 1'b0);
      wait_rv(cyc);
      r0 = o_result;
      chk("t3_rot0", r0, 32'h0000_167C);
      ack_res();
      send(32'h0, 2'd3, 1'b0);
      wait_rv(cyc);
      r3 = o_result;
      chk("t3_rot3", r3, 32'h0000_4ACB);
      checks++;
      if (r0 == r3) begin
         errors++;
         $display("FAIL t3_differ got %h want not %h", r3, r0);
      end
      ack_res();

      // Strobes during BUSY and while result is held are dropped.
      send(32'h1234_5678, 2'd1, 1'b0);
      dr = 1; prog = 0; din = 32'hDEAD_BEEF;
      @(negedge clk);
      dr = 1; prog = 1; din = 32'hFFFF_FFFF;
      @(negedge clk);
      dr = 0; prog = 0;
      wait_rv(cyc);
      chk("t4_result", o_result, enc_f(kk, 32'h1234_5678, 1));
      dr = 1; prog = 0; din = 32'hCAFE_0000;
      repeat (2) @(negedge clk);
      dr = 0;
      chk("t4_rv_held", 32'(o_result_valid), 32'd1);
      ack_res();
      repeat (8) @(negedge clk);
      chk("t4_single_result", 32'(o_result_valid), 32'd0);
      send(32'h0, 2'd0, 1'b0);
      wait_rv(cyc);
      chk("t4_key_unchanged", o_result, 32'h0000_167C);
      ack_res();

      // Rewrite the key while valid: key_valid drops until the load completes.
      key_write(32'hA);
      chk("t5_kv_drop", 32'(o_key_valid), 32'd0);
      chk("t5_ready_drop", 32'(o_ready), 32'd0);
      send(32'h5555_5555, 2'd0, 1'b0);
      repeat (6) @(negedge clk);
      chk("t5_pt_ignored", 32'(o_result_valid), 32'd0);
      key_write(32'hB);
      key_write(32'hC);
      chk("t5_kv_partial", 32'(o_key_valid), 32'd0);
      key_write(32'hD);
      chk("t5_kv_back", 32'(o_key_valid), 32'd1);
      kk[0] = 32'hA; kk[1] = 32'hB; kk[2] = 32'hC; kk[3] = 32'hD;
      send(32'h0BAD_F00D, 2'd2, 1'b0);
      wait_rv(cyc);
      chk("t5_new_key", o_result, enc_f(kk, 32'h0BAD_F00D, 2));
      ack_res();

      // Asynchronous reset in the middle of a block.
      send(32'h7777_0000, 2'd0, 1'b0);
      @(negedge clk);
      #2 rst_n = 0;
      #1;
      chk("t1_ready", 32'(o_ready), 32'd0);
      chk("t1_key_valid", 32'(o_key_valid), 32'd0);
      chk("t1_result", o_result, 32'd0);
      chk("t1_result_valid", 32'(o_result_valid), 32'd0);
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      chk("t1_kv_after", 32'(o_key_valid), 32'd0);
      send(32'h1, 2'd0, 1'b0);
      repeat (6) @(negedge clk);
      chk("t1_no_accept", 32'(o_result_valid), 32'd0);

`ifdef ENCRYPTER_DECRYPT_EN
      for (int n = 0; n < 1000; n++) begin
         for (int i = 0; i < KW; i++) begin
            kk[i] = $urandom;
            key_write(kk[i]);
         end
         d  = $urandom;
         rr = 2'($urandom_range(3, 0));
         send(d, rr, 1'b0);
         wait_rv(cyc);
         c = o_result;
         chk("t6_enc", c, enc_f(kk, d, int'(rr)));
         ack_res();
         send(c, rr, 1'b1);
         wait_rv(cyc);
         chk("t6_roundtrip", o_result, d);
         ack_res();
      end
`endif

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
